// File: rtl/clocking_pkg.sv
// -----------------------------------------------------------------------------
// clocking_pkg
//   Shared definitions for the clock-divider / reset-sequencer block.
//   - fsm_state_e : sequencer state (HOLD, LOCKED, SETTLE)
//   - legal parameter ranges of clk_div_reset_seq
//   - derived widths for the channel index and the stretch counter
// -----------------------------------------------------------------------------
package clocking_pkg;

    typedef enum logic [1:0] {
        HOLD   = 2'd0,  // system held in reset while the stretch counter runs
        LOCKED = 2'd1,  // all channels stable, divider writes accepted
        SETTLE = 2'd2   // waiting for the first ce of a reconfigured channel
    } fsm_state_e;

    // Legal parameter ranges
    localparam int NUM_CH_MIN  = 1;
    localparam int NUM_CH_MAX  = 8;
    localparam int DIV_W_MIN   = 1;
    localparam int DIV_W_MAX   = 16;
    localparam int STRETCH_MIN = 2;
    localparam int STRETCH_MAX = 1023;

    // Channel index covers NUM_CH_MAX channels; stretch counter covers STRETCH_MAX
    localparam int CH_IDX_W  = 3;
    localparam int STRETCH_W = 10;

endpackage

// File: rtl/clk_div_channel.sv
// -----------------------------------------------------------------------------
// clk_div_channel
//   One divided-clock channel. A counter runs 0..div; on the cycle it equals
//   div the channel pulses ce, wraps the counter and toggles clk_out, giving
//   ce at refclk/(div+1) and clk_out at refclk/(2*(div+1)) with 50 % duty.
//
// Ports
//   refclk   in   clock, rising edge
//   resetN   in   asynchronous active-low reset
//   run      in   counting enabled (synchronised reset released)
//   sync     in   phase realign: clears cnt and clk_out next edge, masks ce now
//   load     in   load load_div into div and clear cnt / clk_out next edge
//   load_div in   new divider value
//   ce       out  clock-enable pulse
//   clk_out  out  50 % toggle output
// -----------------------------------------------------------------------------
module clk_div_channel #(
    parameter int               DIV_W    = 8,
    parameter logic [DIV_W-1:0] DIV_INIT = '0
) (
    input  logic             refclk,
    input  logic             resetN,
    input  logic             run,
    input  logic             sync,
    input  logic             load,
    input  logic [DIV_W-1:0] load_div,
    output logic             ce,
    output logic             clk_out
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic             tog;
    logic             hit;

    // Unsigned compare; cnt never passes div because every div change clears cnt.
    assign hit     = (cnt == div);
    // ce is masked during a realign cycle so no pulse escapes while phases reset.
    assign ce      = run & hit & ~sync;
    assign clk_out = tog;

    always_ff @(posedge refclk or negedge resetN) begin
        if (!resetN) begin
            cnt <= '0;
            div <= DIV_INIT;
            tog <= 1'b0;
        end else begin
            if (load) begin
                div <= load_div;
            end
            if (!run || sync || load) begin
                cnt <= '0;
                tog <= 1'b0;
            end else if (hit) begin
                cnt <= '0;
                tog <= ~tog;
            end else begin
                cnt <= cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/clk_div_reset_seq.sv
// -----------------------------------------------------------------------------
// clk_div_reset_seq
//   NUM_CH programmable clock dividers plus a stretched system-reset
//   sequencer. resetN is released through a two-flop synchroniser; the
//   sequencer then holds sys_resetN low for RST_STRETCH cycles before
//   declaring lock. Divider writes are only taken while locked and drop
//   lock until the reconfigured channel produces its first ce.
//
// Ports
//   refclk     in   single clock, rising edge
//   resetN     in   asynchronous active-low reset
//   cfg_valid  in   divider-write request
//   cfg_ready  out  divider write can be accepted (LOCKED only)
//   cfg_ch     in   target channel index (indices >= NUM_CH are discarded)
//   cfg_div    in   new divider value
//   sync_in    in   single-cycle phase-realign strobe for all channels
//   ce_out     out  per-channel clock-enable pulses
//   clk_out    out  per-channel 50 % toggle outputs (to DDR output registers)
//   locked     out  all channels stable
//   sys_resetN out  stretched, synchronously released system reset
//   fsm_state  out  sequencer state, for observation
//
// Config handshake: a write transfers on a rising edge where cfg_valid and
// cfg_ready are both high; cfg_ch/cfg_div must be stable while cfg_valid is
// high; cfg_valid may be raised at any time and the requester keeps it high
// until the transfer; cfg_ready does not depend on cfg_valid.
// -----------------------------------------------------------------------------
module clk_div_reset_seq
    import clocking_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int DIV_W       = 8,
    parameter int DIV_INIT    = 0,
    parameter int RST_STRETCH = 16
) (
    input  logic                refclk,
    input  logic                resetN,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
    input  logic                sync_in,
    output logic [NUM_CH-1:0]   ce_out,
    output logic [NUM_CH-1:0]   clk_out,
    output logic                locked,
    output logic                sys_resetN,
    output fsm_state_e          fsm_state
);

    localparam logic [DIV_W-1:0]     DIV_RST    = DIV_W'(DIV_INIT);
    localparam logic [STRETCH_W-1:0] STRETCH_TC = STRETCH_W'(RST_STRETCH - 1);
    localparam logic [CH_IDX_W:0]    NUM_CH_U   = (CH_IDX_W + 1)'(NUM_CH);

    // -------------------------------------------------------------------------
    // Reset synchroniser: asserts asynchronously, releases after two edges.
    // -------------------------------------------------------------------------
    logic rst_meta;
    logic rst_sync;

    always_ff @(posedge refclk or negedge resetN) begin
        if (!resetN) begin
            rst_meta <= 1'b0;
            rst_sync <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_sync <= rst_meta;
        end
    end

    // -------------------------------------------------------------------------
    // Config decode
    // -------------------------------------------------------------------------
    logic              accept;
    logic              ch_ok;
    logic [NUM_CH-1:0] load_vec;

    assign accept = cfg_valid & cfg_ready;
    // An out-of-range index still completes the handshake but loads nothing.
    assign ch_ok  = ({1'b0, cfg_ch} < NUM_CH_U);

    // -------------------------------------------------------------------------
    // Divider channels
    // -------------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign load_vec[i] = accept & ch_ok & (cfg_ch == CH_IDX_W'(i));

        clk_div_channel #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_RST)
        ) u_ch (
            .refclk   (refclk),
            .resetN   (resetN),
            .run      (rst_sync),
            .sync     (sync_in),
            .load     (load_vec[i]),
            .load_div (cfg_div),
            .ce       (ce_out[i]),
            .clk_out  (clk_out[i])
        );
    end

    // -------------------------------------------------------------------------
    // Sequencer FSM
    // -------------------------------------------------------------------------
    fsm_state_e            state;
    fsm_state_e            state_nxt;
    logic [STRETCH_W-1:0]  stretch_cnt;
    logic [STRETCH_W-1:0]  stretch_nxt;
    logic [CH_IDX_W-1:0]   settle_ch;
    logic [CH_IDX_W-1:0]   settle_ch_nxt;
    logic [NUM_CH_MAX-1:0] ce_pad;

    always_comb begin
        state_nxt           = state;
        stretch_nxt         = stretch_cnt;
        settle_ch_nxt       = settle_ch;
        // Zero-padded so any settle_ch value indexes a defined bit.
        ce_pad              = '0;
        ce_pad[NUM_CH-1:0]  = ce_out;

        unique case (state)
            HOLD: begin
                if (rst_sync) begin
                    if (stretch_cnt == STRETCH_TC) begin
                        state_nxt   = LOCKED;
                        stretch_nxt = '0;
                    end else begin
                        stretch_nxt = stretch_cnt + STRETCH_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (accept && ch_ok) begin
                    state_nxt     = SETTLE;
                    settle_ch_nxt = cfg_ch;
                end
            end
            SETTLE: begin
                if (ce_pad[settle_ch]) begin
                    state_nxt = LOCKED;
                end
            end
            default: begin
                state_nxt = HOLD;
            end
        endcase
    end

    // Status outputs are registered from the next state so they change on the
    // same edge as the state and never glitch on the system reset net.
    always_ff @(posedge refclk or negedge resetN) begin
        if (!resetN) begin
            state       <= HOLD;
            stretch_cnt <= '0;
            settle_ch   <= '0;
            locked      <= 1'b0;
            cfg_ready   <= 1'b0;
            sys_resetN  <= 1'b0;
        end else begin
            state       <= state_nxt;
            stretch_cnt <= stretch_nxt;
            settle_ch   <= settle_ch_nxt;
            locked      <= (state_nxt == LOCKED);
            cfg_ready   <= (state_nxt == LOCKED);
            sys_resetN  <= (state_nxt != HOLD);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_clk_div_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_clk_div_reset_seq
//   Directed bench for clk_div_reset_seq (NUM_CH=2, DIV_INIT=3,
//   RST_STRETCH=16). Inputs change and outputs are sampled on the falling
//   edge; "cycle n" is the interval after the n-th rising edge following
//   reset release. Expected waveforms are hand-derived bit patterns where
//   bit j is the value in the j-th sampled cycle of a window.
// -----------------------------------------------------------------------------
module tb_clk_div_reset_seq;
    import clocking_pkg::*;

    localparam int NUM_CH      = 2;
    localparam int DIV_W       = 8;
    localparam int DIV_INIT    = 3;
    localparam int RST_STRETCH = 16;

    // -------------------------------------------------------------------------
    // Clock / reset
    // -------------------------------------------------------------------------
    logic refclk = 1'b0;
    logic resetN = 1'b1;

    always #5 refclk = ~refclk;

    // -------------------------------------------------------------------------
    // DUT
    // -------------------------------------------------------------------------
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [2:0]        cfg_ch    = '0;
    logic [DIV_W-1:0]  cfg_div   = '0;
    logic              sync_in   = 1'b0;
    logic [NUM_CH-1:0] ce_out;
    logic [NUM_CH-1:0] clk_out;
    logic              locked;
    logic              sys_resetN;
    fsm_state_e        fsm_state;

    clk_div_reset_seq #(
        .NUM_CH      (NUM_CH),
        .DIV_W       (DIV_W),
        .DIV_INIT    (DIV_INIT),
        .RST_STRETCH (RST_STRETCH)
    ) dut (
        .refclk     (refclk),
        .resetN     (resetN),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_div    (cfg_div),
        .sync_in    (sync_in),
        .ce_out     (ce_out),
        .clk_out    (clk_out),
        .locked     (locked),
        .sys_resetN (sys_resetN),
        .fsm_state  (fsm_state)
    );

    // -------------------------------------------------------------------------
    // Checking
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // -------------------------------------------------------------------------
    // Driver tasks
    // -------------------------------------------------------------------------
    task automatic tick();
        @(posedge refclk);
        @(negedge refclk);
    endtask

    // Presents one write and returns in the cycle after the transfer.
    task automatic cfg_write(input logic [2:0] ch, input logic [DIV_W-1:0] div);
        int n;
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_div   = div;
        n = 0;
        while (!cfg_ready && n < 40) begin
            tick();
            n++;
        end
        check_eq($sformatf("cfg_ready_ch%0d", ch), 32'(cfg_ready), 32'd1);
        tick();
        cfg_valid = 1'b0;
    endtask

    // Counts cycles until locked is seen, bounded.
    task automatic wait_locked(output int n);
        n = 0;
        while (!locked && n < 40) begin
            tick();
            n++;
        end
    endtask

    // Asserts reset, checks reset values, releases, checks the lock latency
    // and the DIV_INIT=3 waveforms in cycles 18..33. Returns in cycle 34.
    task automatic reset_and_lock(input string tag);
        int k;
        logic [15:0] ce0_h, ce1_h, ck0_h, ck1_h;
        resetN    = 1'b0;
        cfg_valid = 1'b0;
        sync_in   = 1'b0;
        #1;
        check_eq({tag, "_rst_locked"},  32'(locked),     32'd0);
        check_eq({tag, "_rst_sysrst"},  32'(sys_resetN), 32'd0);
        check_eq({tag, "_rst_ready"},   32'(cfg_ready),  32'd0);
        check_eq({tag, "_rst_ce"},      32'(ce_out),     32'd0);
        check_eq({tag, "_rst_clk"},     32'(clk_out),    32'd0);
        check_eq({tag, "_rst_state"},   32'(fsm_state),  32'(HOLD));
        tick();
        tick();
        tick();
        resetN = 1'b1;
        k = 0;
        while (!(locked || sys_resetN || cfg_ready) && k < 40) begin
            tick();
            k++;
        end
        check_eq({tag, "_lock_cycle"},  32'(k),          32'd18);
        check_eq({tag, "_locked"},      32'(locked),     32'd1);
        check_eq({tag, "_sysrst"},      32'(sys_resetN), 32'd1);
        check_eq({tag, "_ready"},       32'(cfg_ready),  32'd1);
        for (int j = 0; j < 16; j++) begin
            ce0_h[j] = ce_out[0];
            ce1_h[j] = ce_out[1];
            ck0_h[j] = clk_out[0];
            ck1_h[j] = clk_out[1];
            tick();
        end
        // div=3: ce every 4th cycle, clk_out 4 low / 4 high
        check_eq({tag, "_ce0_div3"},  32'(ce0_h), 32'h8888);
        check_eq({tag, "_ce1_div3"},  32'(ce1_h), 32'h8888);
        check_eq({tag, "_clk0_div3"}, 32'(ck0_h), 32'hF0F0);
        check_eq({tag, "_clk1_div3"}, 32'(ck1_h), 32'hF0F0);
    endtask

    // -------------------------------------------------------------------------
    // Stimulus
    // -------------------------------------------------------------------------
    initial begin : main
        int          n;
        logic [11:0] lk_h, rdy_h, ce0_h, ce1_h, ck0_h, ck1_h;

        #2;
        // Power-on reset, lock latency 2 + 16, DIV_INIT waveforms
        reset_and_lock("por");

        // Write ch1 div=5 in cycle 34; window covers cycles 35..41
        cfg_write(3'd1, 8'd5);
        lk_h = '0; rdy_h = '0; ce0_h = '0; ce1_h = '0; ck0_h = '0; ck1_h = '0;
        for (int j = 0; j < 7; j++) begin
            lk_h[j]  = locked;
            rdy_h[j] = cfg_ready;
            ce0_h[j] = ce_out[0];
            ce1_h[j] = ce_out[1];
            ck0_h[j] = clk_out[0];
            ck1_h[j] = clk_out[1];
            if (j < 6) tick();
        end
        check_eq("reload_locked", 32'(lk_h),  32'b100_0000);
        check_eq("reload_ready",  32'(rdy_h), 32'b100_0000);
        check_eq("reload_ce1",    32'(ce1_h), 32'b010_0000);
        check_eq("reload_clk1",   32'(ck1_h), 32'b100_0000);
        check_eq("reload_ce0",    32'(ce0_h), 32'b100_0100);
        check_eq("reload_clk0",   32'(ck0_h), 32'b111_1000);

        // Out-of-range channel 7 in cycle 41; window covers cycles 42..53
        cfg_write(3'd7, 8'd0);
        for (int j = 0; j < 12; j++) begin
            lk_h[j]  = locked;
            rdy_h[j] = cfg_ready;
            ce0_h[j] = ce_out[0];
            ce1_h[j] = ce_out[1];
            if (j < 11) tick();
        end
        check_eq("badch_locked", 32'(lk_h),  32'hFFF);
        check_eq("badch_ready",  32'(rdy_h), 32'hFFF);
        check_eq("badch_ce0",    32'(ce0_h), 32'b1000_1000_1000);
        check_eq("badch_ce1",    32'(ce1_h), 32'b0100_0001_0000);

        // ch0 div=2 then ch1 div=4; lock returns after div+1 cycles each
        cfg_write(3'd0, 8'd2);
        wait_locked(n);
        check_eq("settle_ch0_div2", 32'(n), 32'd3);
        cfg_write(3'd1, 8'd4);
        wait_locked(n);
        check_eq("settle_ch1_div4", 32'(n), 32'd5);

        // Cycle 63: both counters at 0. Cycle 65: ch0 at its terminal count.
        tick();
        tick();
        sync_in = 1'b1;
        #1;
        check_eq("sync_ce_masked", 32'(ce_out), 32'd0);
        tick();
        sync_in = 1'b0;
        check_eq("sync_clk_clear", 32'(clk_out), 32'd0);
        ce0_h = '0; ce1_h = '0; ck0_h = '0; ck1_h = '0;
        for (int j = 0; j < 6; j++) begin
            ce0_h[j] = ce_out[0];
            ce1_h[j] = ce_out[1];
            ck0_h[j] = clk_out[0];
            ck1_h[j] = clk_out[1];
            if (j < 5) tick();
        end
        check_eq("sync_ce0",  32'(ce0_h), 32'b10_0100);
        check_eq("sync_ce1",  32'(ce1_h), 32'b01_0000);
        check_eq("sync_clk0", 32'(ck0_h), 32'b11_1000);
        check_eq("sync_clk1", 32'(ck1_h), 32'b10_0000);
        check_eq("sync_locked", 32'(locked), 32'd1);

        // Reset during SETTLE: pending reload of ch1 is discarded
        cfg_write(3'd1, 8'd5);
        check_eq("settle_locked", 32'(locked),    32'd0);
        check_eq("settle_state",  32'(fsm_state), 32'(SETTLE));
        check_eq("settle_sysrst", 32'(sys_resetN), 32'd1);
        tick();
        tick();
        reset_and_lock("mid_settle");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Safety net against a stalled run
    initial begin : watchdog
        #200000;
        n_fail++;
        $display("FAIL watchdog: observed timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
